collatz_engine: RTL and testbench
=================================

// Module: collatz_engine
// PURPOSE
//  Parametrised Collatz sequence engine: accepts a start number over a valid/ready handshake and
//  iterates n/2 (even) or 3n+1 (odd), one step per step_en tick, until n==1.
//  Reports current value, step count, peak value and a terminal status.
//  Sits between the switch/start logic and the BCD display path; step_en comes from the
//  divided slow clock, so this block runs in the fast clk domain.
// PARAMETERS
//  WIDTH   13  bit width of n (start_num, cur_num, peak)
//  STEP_W  10  bit width of the step counter; saturation is a fault
// PORTS
//  clk          in   1       system clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start_valid  in   1       start_num is offered
//  start_ready  out  1       engine can accept a start (IDLE, DONE or FAULT)
//  start_num    in   WIDTH   initial n
//  pause        in   1       1 = hold all state in RUN; step_en ticks are ignored
//  step_en      in   1       single-cycle tick; one iteration per tick in RUN
//  cur_num      out  WIDTH   current n
//  steps        out  STEP_W  iterations taken
//  peak         out  WIDTH   largest value reached, including start_num
//  busy         out  1       state == RUN
//  done         out  1       one-cycle pulse when n reaches 1
//  status       out  2       00 ok/running, 01 overflow, 10 zero start, 11 step saturate
// BEHAVIOUR
//  Clock and reset
//   - Single clock, clk. reset_n is asynchronous and active-low.
//   - On reset: state=IDLE, all outputs 0 except start_ready=1.
//   - Reset mid-RUN aborts the run immediately. No done pulse is produced.
//  State machine: IDLE, RUN, DONE, FAULT
//   - Accept: start_valid & start_ready on edge T.
//     - cur_num<=start_num, peak<=start_num, steps<=0, status<=00.
//     - start_num==0 -> FAULT, status=10.
//     - start_num==1 -> DONE, done=1 in cycle T+1.
//     - Otherwise -> RUN, busy=1 from T+1.
//   - In RUN, start_valid is ignored (start_ready=0).
//  RUN step (on a step_en=1 edge with pause=0)
//   - Even n: nxt=n>>1.
//   - Odd n: t=3n+1, computed at WIDTH+2 bits.
//     - If t > 2^WIDTH-1: status<=01, state FAULT; cur_num, steps and peak unchanged.
//     - Else nxt=t.
//   - steps<=steps+1.
//     - If steps+1 == 2^STEP_W-1 and nxt!=1: commit, status<=11, state FAULT.
//   - peak<=max(peak, every value produced this step).
//   - If nxt==1: state DONE, with done high for exactly the following cycle.
//  Terminal states
//   - DONE and FAULT hold all outputs until the next accepted start.
//   - DONE/FAULT -> RUN directly on accept; no IDLE visit.
//  Timing
//   - Latency: one step_en tick per iteration; outputs register at the step edge.
//   - pause=1 and step_en=1 on the same edge: no step occurs, and the tick is lost (not queued).
//   - Accept and step_en on the same edge: only the accept takes effect.
// CONFIGURATION
//  COLLATZ_SHORTCUT_EN
//   - Defined: an odd step produces (3n+1)/2 in one tick.
//     - steps advances by 2; peak still includes the intermediate 3n+1.
//     - Overflow is checked on 3n+1.
//     - Saturation: if steps+2 > 2^STEP_W-1, clamp steps to 2^STEP_W-1 and take status 11.
//   - Undefined: plain one-operation-per-tick behaviour as above.
//   - Final steps, peak and status are identical in both builds; only the tick count differs.
// TESTING
//  1. start 6, step_en every cycle:
//     cur_num 6,3,10,5,16,8,4,2,1; steps=8, peak=16, done one pulse, status=00.
//  2. WIDTH=13, start 27:
//     3*3077+1=9232 > 8191 -> status=01, cur_num=3077 held, FAULT, no done.
//     WIDTH=14: steps=111, peak=9232, status=00.
//  3. start 0 -> status=10, FAULT, start_ready=1.
//     start 1 -> DONE next cycle, steps=0, done pulse.
//  4. start 7; pause=1 for 5 ticks mid-run -> cur_num/steps frozen.
//     Resume -> final steps=16, peak=52.
//  5. STEP_W=4, start 27 -> steps saturates at 15, status=11.
//     Reset_n low mid-RUN -> all outputs 0 asynchronously.
//  6. COLLATZ_SHORTCUT_EN, start 6:
//     cur_num 6,3,5,8,4,2,1 (6 ticks); steps=8, peak=16.
//     start_valid held during RUN is not accepted.

Source files
------------

// File: rtl/collatz_engine.sv
// Collatz sequence engine: takes a start number over valid/ready, then iterates one step per step_en tick until n==1.
// Build macro COLLATZ_SHORTCUT_EN folds each odd step into a single (3n+1)/2 tick.
module collatz_engine #(
   parameter int WIDTH  = 13,
   parameter int STEP_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [WIDTH-1:0]  start_num,
   input  logic              pause,
   input  logic              step_en,
   output logic [WIDTH-1:0]  cur_num,
   output logic [STEP_W-1:0] steps,
   output logic [WIDTH-1:0]  peak,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [1:0]        state_dbg
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_OVF  = 2'b01;
   localparam logic [1:0] ST_ZERO = 2'b10;
   localparam logic [1:0] ST_SAT  = 2'b11;

   localparam logic [WIDTH+1:0]  N_MAX      = {2'b00, {WIDTH{1'b1}}};
   localparam logic [WIDTH+1:0]  TRIPLE_ONE = (WIDTH+2)'(1);
   localparam logic [WIDTH-1:0]  N_ZERO     = '0;
   localparam logic [WIDTH-1:0]  N_ONE      = WIDTH'(1);
   localparam logic [STEP_W-1:0] STEPS_MAX  = '1;
   localparam logic [STEP_W:0]   STEP_ONE   = (STEP_W+1)'(1);
   localparam logic [STEP_W:0]   STEP_TWO   = (STEP_W+1)'(2);

   logic [1:0] state;

   // Handshake: a start is taken on any clk edge where start_valid and start_ready
   // are both high; start_ready is low only while a run is in progress.
   assign start_ready = (state != S_RUN);
   assign busy        = (state == S_RUN);
   assign state_dbg   = state;

   logic              odd;
   logic [WIDTH+1:0]  triple;
   logic              overflow;
   logic [WIDTH-1:0]  nxt;
   logic [WIDTH-1:0]  peak_cand;
   logic [STEP_W:0]   steps_sum;
   logic [STEP_W-1:0] steps_nxt;
   logic              reach_one;
   logic              saturate;
   logic              step_fire;

   // 3n+1 is formed two bits wider than n so the overflow test sees the true value
   assign odd      = cur_num[0];
   assign triple   = {2'b00, cur_num} + {1'b0, cur_num, 1'b0} + TRIPLE_ONE;
   assign overflow = odd && (triple > N_MAX);

`ifdef COLLATZ_SHORTCUT_EN
   always_comb begin
      nxt       = cur_num >> 1;
      peak_cand = cur_num >> 1;
      steps_sum = {1'b0, steps} + STEP_ONE;
      if (odd) begin
         nxt       = triple[WIDTH:1];
         peak_cand = triple[WIDTH-1:0];
         steps_sum = {1'b0, steps} + STEP_TWO;
      end
   end
`else
   always_comb begin
      nxt       = cur_num >> 1;
      peak_cand = cur_num >> 1;
      steps_sum = {1'b0, steps} + STEP_ONE;
      if (odd) begin
         nxt       = triple[WIDTH-1:0];
         peak_cand = triple[WIDTH-1:0];
      end
   end
`endif

   // A double step may overshoot the counter ceiling; it is clamped and faulted
   assign steps_nxt = (steps_sum > {1'b0, STEPS_MAX}) ? STEPS_MAX : steps_sum[STEP_W-1:0];
   assign reach_one = (nxt == N_ONE);
   assign saturate  = (steps_sum >= {1'b0, STEPS_MAX}) && !reach_one;
   assign step_fire = step_en && !pause;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         cur_num <= '0;
         steps   <= '0;
         peak    <= '0;
         done    <= 1'b0;
         status  <= ST_OK;
      end else begin
         done <= 1'b0;
         case (state)
            S_RUN: begin
               if (step_fire) begin
                  if (overflow) begin
                     status <= ST_OVF;
                     state  <= S_FAULT;
                  end else begin
                     cur_num <= nxt;
                     steps   <= steps_nxt;
                     if (peak_cand > peak) begin
                        peak <= peak_cand;
                     end
                     if (reach_one) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else if (saturate) begin
                        status <= ST_SAT;
                        state  <= S_FAULT;
                     end
                  end
               end
            end
            default: begin
               // IDLE, DONE and FAULT all accept a new start directly
               if (start_valid) begin
                  cur_num <= start_num;
                  peak    <= start_num;
                  steps   <= '0;
                  status  <= ST_OK;
                  if (start_num == N_ZERO) begin
                     status <= ST_ZERO;
                     state  <= S_FAULT;
                  end else if (start_num == N_ONE) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: three instances (13/10, 13/4, 14/10 bit) share one stimulus stream
// and are checked against an integer Collatz model; honours COLLATZ_SHORTCUT_EN like the design.
module tb_collatz_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        pause = 1'b0;
   logic        step_en = 1'b0;
   logic [13:0] start_num = '0;

   logic        a_ready, a_busy, a_done;
   logic [12:0] a_cur, a_peak;
   logic [9:0]  a_steps;
   logic [1:0]  a_status, a_state;

   logic        b_ready, b_busy, b_done;
   logic [12:0] b_cur, b_peak;
   logic [3:0]  b_steps;
   logic [1:0]  b_status, b_state;

   logic        c_ready, c_busy, c_done;
   logic [13:0] c_cur, c_peak;
   logic [9:0]  c_steps;
   logic [1:0]  c_status, c_state;

   int checks = 0;
   int errors = 0;
   logic [12:0] exp_q[$];

   always #5 clk = ~clk;

   collatz_engine #(.WIDTH(13), .STEP_W(10)) dut_a (
      .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(a_ready),
      .start_num(start_num[12:0]), .pause(pause), .step_en(step_en), .cur_num(a_cur),
      .steps(a_steps), .peak(a_peak), .busy(a_busy), .done(a_done), .status(a_status),
      .state_dbg(a_state)
   );

   collatz_engine #(.WIDTH(13), .STEP_W(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(b_ready),
      .start_num(start_num[12:0]), .pause(pause), .step_en(step_en), .cur_num(b_cur),
      .steps(b_steps), .peak(b_peak), .busy(b_busy), .done(b_done), .status(b_status),
      .state_dbg(b_state)
   );

   collatz_engine #(.WIDTH(14), .STEP_W(10)) dut_c (
      .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(c_ready),
      .start_num(start_num), .pause(pause), .step_en(step_en), .cur_num(c_cur),
      .steps(c_steps), .peak(c_peak), .busy(c_busy), .done(c_done), .status(c_status),
      .state_dbg(c_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Whole-run reference: walks the sequence with plain integers; optionally records
   // the value of n after every effective tick into exp_q.
   task automatic model_run(input int unsigned s, input int w, input int sw, input bit record,
                            output int unsigned m_cur, output int unsigned m_steps,
                            output int unsigned m_peak, output int unsigned m_status,
                            output int unsigned m_done);
      longint unsigned n, t, nmax, smax, st, pk;
      bit fin;
      n = s; st = 0; pk = s; m_status = 0; m_done = 0; fin = 0;
      nmax = (64'd1 << w) - 1;
      smax = (64'd1 << sw) - 1;
      if (record) exp_q.delete();
      if (s == 0) m_status = 2;
      else if (s == 1) m_done = 1;
      else begin
         while (!fin) begin
            if (n % 2 == 1) begin
               t = 3 * n + 1;
               if (t > nmax) begin
                  m_status = 1;
                  fin = 1;
               end else begin
`ifdef COLLATZ_SHORTCUT_EN
                  if (t > pk) pk = t;
                  n = t / 2;
                  st += 2;
`else
                  n = t;
                  st += 1;
`endif
               end
            end else begin
               n = n / 2;
               st += 1;
            end
            if (!fin) begin
               if (n > pk) pk = n;
               if (st > smax) st = smax;
               if (record) exp_q.push_back(13'(n));
               if (n == 1) begin
                  m_done = 1;
                  fin = 1;
               end else if (st >= smax) begin
                  m_status = 3;
                  fin = 1;
               end
            end
         end
      end
      m_cur = 32'(n); m_steps = 32'(st); m_peak = 32'(pk);
   endtask

   task automatic run_start(input int unsigned s, input int pause_pct);
      int unsigned ac, as, ap, ast, ad, bc, bs, bp, bst, bd, cc, cs, cp, cst, cd;
      int da, db, dc, cyc;
      logic [12:0] last_a, exp_cur;
      logic was_busy, eff;
      model_run(s, 13, 10, 1'b1, ac, as, ap, ast, ad);
      model_run(s, 13, 4, 1'b0, bc, bs, bp, bst, bd);
      model_run(s, 14, 10, 1'b0, cc, cs, cp, cst, cd);

      @(negedge clk);
      start_num = 14'(s);
      start_valid = 1'b1;
      step_en = 1'(($urandom_range(0, 1)));
      pause = 1'b0;
      @(posedge clk); #1;
      start_valid = 1'b0;
      step_en = 1'b0;
      check("acc_cur", 32'(a_cur), s);
      check("acc_steps", 32'(a_steps), 0);
      check("acc_peak", 32'(a_peak), s);
      check("acc_busy", 32'(a_busy), 32'(s > 1));
      da = int'(a_done); db = int'(b_done); dc = int'(c_done);
      last_a = a_cur;
      cyc = 0;

      while ((a_busy || b_busy || c_busy) && cyc < 5000) begin
         @(negedge clk);
         step_en = ($urandom_range(0, 99) < 60);
         pause = ($urandom_range(0, 99) < pause_pct);
         if (a_busy && b_busy && c_busy && $urandom_range(0, 3) == 0) begin
            start_valid = 1'b1;
            start_num = 14'($urandom_range(0, 8191));
         end else begin
            start_valid = 1'b0;
         end
         was_busy = a_busy;
         @(posedge clk); #1;
         eff = was_busy && step_en && !pause;
         if (eff && exp_q.size() > 0) exp_cur = exp_q.pop_front();
         else exp_cur = last_a;
         check("cur_trace", 32'(a_cur), 32'(exp_cur));
         last_a = exp_cur;
         da += int'(a_done); db += int'(b_done); dc += int'(c_done);
         cyc++;
      end
      start_valid = 1'b0;
      step_en = 1'b0;
      pause = 1'b0;
      check("run_timeout", 32'(cyc < 5000), 1);
      check("trace_left", 32'(exp_q.size()), 0);

      check("a_cur", 32'(a_cur), ac);     check("a_steps", 32'(a_steps), as);
      check("a_peak", 32'(a_peak), ap);   check("a_status", 32'(a_status), ast);
      check("b_cur", 32'(b_cur), bc);     check("b_steps", 32'(b_steps), bs);
      check("b_peak", 32'(b_peak), bp);   check("b_status", 32'(b_status), bst);
      check("c_cur", 32'(c_cur), cc);     check("c_steps", 32'(c_steps), cs);
      check("c_peak", 32'(c_peak), cp);   check("c_status", 32'(c_status), cst);
      check("a_ready", 32'(a_ready), 1);  check("b_ready", 32'(b_ready), 1);
      check("c_ready", 32'(c_ready), 1);

      // Terminal states hold; done must already have dropped
      @(posedge clk); #1;
      da += int'(a_done); db += int'(b_done); dc += int'(c_done);
      check("a_done_cnt", 32'(da), ad);
      check("b_done_cnt", 32'(db), bd);
      check("c_done_cnt", 32'(dc), cd);
      check("a_hold_cur", 32'(a_cur), ac);
      check("a_hold_steps", 32'(a_steps), as);
   endtask

   initial begin
      int unsigned dir[6];
      dir = '{6, 27, 0, 1, 7, 3};

      #2;
      check("rst_ready", 32'(a_ready), 1);
      check("rst_cur", 32'(a_cur), 0);
      check("rst_steps", 32'(a_steps), 0);
      check("rst_peak", 32'(a_peak), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_done", 32'(a_done), 0);
      check("rst_status", 32'(a_status), 0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (dir[i]) run_start(dir[i], (dir[i] == 7) ? 40 : 10);
      for (int i = 0; i < 12; i++) run_start($urandom_range(2, 400), $urandom_range(0, 30));
      for (int i = 0; i < 8; i++) run_start($urandom_range(0, 8191), $urandom_range(0, 30));

      // Asynchronous reset in the middle of a run
      @(negedge clk);
      start_num = 14'd27;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      step_en = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("arst_cur", 32'(a_cur), 0);
      check("arst_steps", 32'(a_steps), 0);
      check("arst_peak", 32'(a_peak), 0);
      check("arst_busy", 32'(a_busy), 0);
      check("arst_done", 32'(a_done), 0);
      check("arst_status", 32'(a_status), 0);
      check("arst_ready", 32'(a_ready), 1);
      check("arst_c_cur", 32'(c_cur), 0);
      step_en = 1'b0;
      @(posedge clk); #1;
      check("arst_done_hold", 32'(a_done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_start(6, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
